// File: rtl/pll_loop_filter.sv
// PI loop filter for the external PLL path: ADC sample error -> saturating P+I
// correction offset to DAC midscale, one sample in flight over a 6-state sequence.
module pll_loop_filter #(
    parameter int ADC_WIDTH  = 16,
    parameter int DAC_WIDTH  = 16,
    parameter int GAIN_WIDTH = 16,
    parameter int FRAC_BITS  = 12,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [ADC_WIDTH-1:0]  sample_in,
    input  logic [ADC_WIDTH-1:0]  setpoint,
    input  logic [GAIN_WIDTH-1:0] kp,
    input  logic [GAIN_WIDTH-1:0] ki,
    output logic [DAC_WIDTH-1:0]  dac_code,
    output logic                  dac_valid,
    output logic                  busy,
    output logic                  integ_sat,
    output logic                  out_clamped,
    output logic [7:0]            overrun_count
);

    localparam int ERR_W  = ADC_WIDTH + 1;
    localparam int PROD_W = ADC_WIDTH + GAIN_WIDTH + 1;
    localparam int SUM_W  = ACC_WIDTH + 2;

    localparam logic [DAC_WIDTH-1:0] DAC_MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic [SUM_W-1:0]     SUM_MID = {{(SUM_W-DAC_WIDTH){1'b0}}, DAC_MID};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ERR, MUL, ACC, SUM, OUT} state_t;

    state_t                 state_q, state_d;
    logic [ADC_WIDTH-1:0]   sample_q, sample_d;
    logic [ADC_WIDTH-1:0]   setpoint_q, setpoint_d;
    logic [GAIN_WIDTH-1:0]  kp_q, kp_d;
    logic [GAIN_WIDTH-1:0]  ki_q, ki_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic [ACC_WIDTH-1:0]   p_q, p_d;
    logic [ACC_WIDTH-1:0]   iterm_q, iterm_d;
    logic [ACC_WIDTH-1:0]   integ_q, integ_d;
    logic [DAC_WIDTH-1:0]   dac_code_q, dac_code_d;
    logic                   dac_valid_q, dac_valid_d;
    logic                   busy_q, busy_d;
    logic                   integ_sat_q, integ_sat_d;
    logic                   out_clamped_q, out_clamped_d;
    logic [7:0]             overrun_q, overrun_d;

    logic signed [PROD_W-1:0]  err_ext, kp_ext, ki_ext, p_full, i_full;
    logic signed [ACC_WIDTH:0] acc_sum;
    logic signed [SUM_W-1:0]   pi_sum, u_val;

    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        setpoint_d    = setpoint_q;
        kp_d          = kp_q;
        ki_d          = ki_q;
        err_d         = err_q;
        p_d           = p_q;
        iterm_d       = iterm_q;
        integ_d       = integ_q;
        dac_code_d    = dac_code_q;
        dac_valid_d   = 1'b0;
        integ_sat_d   = integ_sat_q;
        out_clamped_d = out_clamped_q;
        overrun_d     = overrun_q;

        err_ext = signed'({{GAIN_WIDTH{err_q[ERR_W-1]}}, err_q});
        kp_ext  = signed'({{(ADC_WIDTH+1){1'b0}}, kp_q});
        ki_ext  = signed'({{(ADC_WIDTH+1){1'b0}}, ki_q});
        p_full  = err_ext * kp_ext;
        i_full  = err_ext * ki_ext;
        acc_sum = signed'({integ_q[ACC_WIDTH-1], integ_q}) + signed'({iterm_q[ACC_WIDTH-1], iterm_q});
        pi_sum  = signed'({{2{p_q[ACC_WIDTH-1]}}, p_q}) + signed'({{2{integ_q[ACC_WIDTH-1]}}, integ_q});
        u_val   = (pi_sum >>> FRAC_BITS) + signed'(SUM_MID);

        if (sample_valid && state_q != IDLE && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    integ_d    = '0;
                    dac_code_d = DAC_MID;
                end else if (sample_valid) begin
                    sample_d   = sample_in;
                    setpoint_d = setpoint;
                    kp_d       = kp;
                    ki_d       = ki;
                    state_d    = ERR;
                end
            end
            ERR: begin
                err_d   = {1'b0, sample_q} - {1'b0, setpoint_q};
                state_d = MUL;
            end
            MUL: begin
                p_d     = {{(ACC_WIDTH-PROD_W){p_full[PROD_W-1]}}, p_full};
                iterm_d = {{(ACC_WIDTH-PROD_W){i_full[PROD_W-1]}}, i_full};
                state_d = ACC;
            end
            ACC: begin
                // Overflow shows as the top two bits of the widened sum disagreeing.
                integ_sat_d = acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1];
                if (!integ_sat_d)
                    integ_d = acc_sum[ACC_WIDTH-1:0];
                else if (acc_sum[ACC_WIDTH])
                    integ_d = ACC_MIN;
                else
                    integ_d = ACC_MAX;
                state_d = SUM;
            end
            SUM: begin
                // Registered here so dac_code/dac_valid are visible during OUT.
                out_clamped_d = 1'b1;
                if (u_val[SUM_W-1])
                    dac_code_d = '0;
                else if (u_val[SUM_W-2:DAC_WIDTH] != '0)
                    dac_code_d = '1;
                else begin
                    dac_code_d    = u_val[DAC_WIDTH-1:0];
                    out_clamped_d = 1'b0;
                end
                dac_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            sample_q      <= '0;
            setpoint_q    <= '0;
            kp_q          <= '0;
            ki_q          <= '0;
            err_q         <= '0;
            p_q           <= '0;
            iterm_q       <= '0;
            integ_q       <= '0;
            dac_code_q    <= DAC_MID;
            dac_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            integ_sat_q   <= 1'b0;
            out_clamped_q <= 1'b0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            setpoint_q    <= setpoint_d;
            kp_q          <= kp_d;
            ki_q          <= ki_d;
            err_q         <= err_d;
            p_q           <= p_d;
            iterm_q       <= iterm_d;
            integ_q       <= integ_d;
            dac_code_q    <= dac_code_d;
            dac_valid_q   <= dac_valid_d;
            busy_q        <= busy_d;
            integ_sat_q   <= integ_sat_d;
            out_clamped_q <= out_clamped_d;
            overrun_q     <= overrun_d;
        end
    end

    assign dac_code      = dac_code_q;
    assign dac_valid     = dac_valid_q;
    assign busy          = busy_q;
    assign integ_sat     = integ_sat_q;
    assign out_clamped   = out_clamped_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Directed bench for pll_loop_filter: hand-computed codes for P, I ramp, clamps,
// overrun, enable hold, integrator saturation and asynchronous reset abort.
module tb_pll_loop_filter;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic [15:0] setpoint;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] dac_code;
    logic        dac_valid;
    logic        busy;
    logic        integ_sat;
    logic        out_clamped;
    logic [7:0]  overrun_count;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int vcount = 0;
    int v0;

    pll_loop_filter #(
        .ADC_WIDTH(16), .DAC_WIDTH(16), .GAIN_WIDTH(16), .FRAC_BITS(12), .ACC_WIDTH(40)
    ) dut (
        .clk(clk), .areset(areset), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in), .setpoint(setpoint), .kp(kp), .ki(ki),
        .dac_code(dac_code), .dac_valid(dac_valid), .busy(busy), .integ_sat(integ_sat),
        .out_clamped(out_clamped), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dac_valid === 1'b1) vcount = vcount + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full sample: accept, check busy across the flight, code/valid at T+5, idle at T+6.
    task automatic run(input int s, input int sp, input int k_p, input int k_i,
                       input int exp_code, input string tag);
        int vs;
        sample_in = 16'(s); setpoint = 16'(sp); kp = 16'(k_p); ki = 16'(k_i);
        sample_valid = 1'b1;
        vs = vcount;
        tick();
        sample_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            tick();
        end
        chk({tag, "_busy5"}, 64'(busy), 64'd1);
        chk({tag, "_valid"}, 64'(dac_valid), 64'd1);
        chk({tag, "_code"}, 64'(dac_code), 64'(exp_code));
        tick();
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_vpulse"}, 64'(vcount), 64'(vs + 1));
    endtask

    initial begin
        areset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        sample_in = '0; setpoint = '0; kp = '0; ki = '0;
        tick(); tick();
        chk("rst_code", 64'(dac_code), 64'd32768);
        chk("rst_valid", 64'(dac_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_isat", 64'(integ_sat), 64'd0);
        chk("rst_oclamp", 64'(out_clamped), 64'd0);
        chk("rst_ovr", 64'(overrun_count), 64'd0);
        areset = 1'b0;
        enable = 1'b1;
        tick();

        // err=1000, gain 1.0 -> 32768+1000
        run(33768, 32768, 4096, 0, 33768, "prop");
        chk("prop_oclamp", 64'(out_clamped), 64'd0);

        // integ grows by 4096 (1.0 LSB) per sample
        run(32769, 32768, 0, 4096, 32769, "ramp1");
        repeat (4) tick();
        run(32769, 32768, 0, 4096, 32770, "ramp2");
        repeat (4) tick();
        run(32769, 32768, 0, 4096, 32771, "ramp3");
        chk("ramp_isat", 64'(integ_sat), 64'd0);

        // loop open: midscale, integ cleared, strobes ignored uncounted
        v0 = vcount;
        enable = 1'b0; sample_valid = 1'b1;
        tick(); tick();
        sample_valid = 1'b0;
        chk("dis_code", 64'(dac_code), 64'd32768);
        chk("dis_novalid", 64'(vcount), 64'(v0));
        chk("dis_ovr", 64'(overrun_count), 64'd0);
        enable = 1'b1;
        tick();
        run(32769, 32768, 0, 4096, 32769, "reen");

        // overrun: second strobe two cycles after acceptance
        v0 = vcount;
        sample_in = 16'd33768; setpoint = 16'd32768; kp = 16'd4096; ki = 16'd0;
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0; tick();
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0;
        chk("ovr_one", 64'(overrun_count), 64'd1);
        repeat (5) tick();
        chk("ovr_code", 64'(dac_code), 64'd33768 + 64'd4096 / 4096 * 0 + 64'd1);
        chk("ovr_single", 64'(vcount), 64'(v0 + 1));
        chk("ovr_busy", 64'(busy), 64'd0);

        // clamps (residual integ 4096 is negligible against the P term)
        run(65535, 0, 65535, 0, 65535, "clamp_hi");
        chk("clamp_hi_flag", 64'(out_clamped), 64'd1);
        run(0, 65535, 65535, 0, 0, "clamp_lo");
        chk("clamp_lo_flag", 64'(out_clamped), 64'd1);

        // continuous strobes: 5 drops per accepted sample, counter saturates
        sample_in = 16'd100; setpoint = 16'd100; kp = '0; ki = '0;
        sample_valid = 1'b1;
        repeat (400) tick();
        sample_valid = 1'b0;
        repeat (8) tick();
        chk("ovr_sat", 64'(overrun_count), 64'd255);

        // integ + 4096 + n*65535^2 crosses 2^39-1 on the 129th sample
        for (int n = 1; n <= 128; n++) begin
            run(65535, 0, 0, 65535, 65535, "isat_run");
        end
        chk("isat_128", 64'(integ_sat), 64'd0);
        run(65535, 0, 0, 65535, 65535, "isat_129");
        chk("isat_129_flag", 64'(integ_sat), 64'd1);

        // asynchronous reset at T+2 aborts the sample
        v0 = vcount;
        sample_in = 16'd33768; setpoint = 16'd32768; kp = 16'd4096; ki = 16'd4096;
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0; tick();
        areset = 1'b1;
        #1;
        chk("ar_code", 64'(dac_code), 64'd32768);
        chk("ar_valid", 64'(dac_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_isat", 64'(integ_sat), 64'd0);
        chk("ar_oclamp", 64'(out_clamped), 64'd0);
        chk("ar_ovr", 64'(overrun_count), 64'd0);
        tick(); tick();
        areset = 1'b0;
        repeat (6) tick();
        chk("ar_novalid", 64'(vcount), 64'(v0));
        run(32769, 32768, 0, 4096, 32769, "post_rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
